// File: rtl/commit_queue_pkg.sv
// -----------------------------------------------------------------------------
// commit_queue_pkg
// Shared constants and small helpers for the writeback/commit stage.
// Holds the default geometry (data width, register address width, number of
// writeback sources, queue depth) plus index helpers used by the round-robin
// arbiter and the commit FIFO.
// No ports (package).
// -----------------------------------------------------------------------------
package commit_queue_pkg;

    // Default geometry of the commit stage.
    localparam int CQ_XLEN  = 32;
    localparam int CQ_AW    = 5;
    localparam int CQ_NSRC  = 2;
    localparam int CQ_DEPTH = 4;

    // Width of an index able to address n items (at least one bit so that
    // degenerate single-item configurations still have a legal vector).
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Source visited at scan position 'off' when the round-robin scan starts
    // at 'base'.
    function automatic int rrIndex(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// -----------------------------------------------------------------------------
// commit_fifo
// In-order storage for pending commits. WIDTH-bit entries, DEPTH deep
// (power of two), with an occupancy counter one bit wider than the pointers
// so that "full" and "empty" are unambiguous.
// Ports:
//   clock, reset      : clock and asynchronous active-high reset
//   push_i, pushData_i: enqueue request and entry (ignored while full)
//   pop_i             : dequeue request (ignored while empty)
//   headData_o        : entry at the head of the queue
//   full_o, empty_o   : occupancy status
// -----------------------------------------------------------------------------
module commit_fifo
    import commit_queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] headData_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = idxWidth(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Requests are qualified here so the storage can never over- or underflow,
    // whatever the caller does.
    assign full_o     = (r_count == CW'(DEPTH));
    assign empty_o    = (r_count == '0);
    assign w_push     = push_i && !full_o;
    assign w_pop      = pop_i && !empty_o;
    assign headData_o = r_mem[r_rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two; the count only
    // moves when exactly one of push/pop happens.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage is not reset: an empty queue never exposes its contents, the
    // top masks the head while empty.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= pushData_i;
        end
    end

endmodule

// File: rtl/commit_queue.sv
// -----------------------------------------------------------------------------
// commit_queue
// Writeback/commit stage. Results from NSRC execution sources are accepted one
// per cycle through a round-robin arbiter, buffered in an in-order queue and
// drained one per cycle into the register-file write port. Each drain yields a
// registered one-cycle commit pulse (one cycle after the write) and bumps a
// 64-bit retire counter.
// Ports:
//   clock, reset                 : clock and asynchronous active-high reset
//   valid_pre_i / ready_pre_o    : per-source handshake (slice i = source i)
//   wen_i, rd_i, wdata_i, pc_i   : per-source result payload
//   halt_i                       : blocks draining, enqueue continues
//   we_o, waddr_o, wdata_o       : register-file write port
//   commit_valid_o, commit_pc_o  : registered commit pulse and its PC
//   retire_cnt_o                 : retired instruction count (wraps at 2^64)
//   full_o, empty_o              : queue status
// -----------------------------------------------------------------------------
module commit_queue
    import commit_queue_pkg::*;
#(
    parameter int NSRC  = CQ_NSRC,
    parameter int DEPTH = CQ_DEPTH,
    parameter int XLEN  = CQ_XLEN,
    parameter int AW    = CQ_AW
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NSRC-1:0]      valid_pre_i,
    output logic [NSRC-1:0]      ready_pre_o,
    input  logic [NSRC-1:0]      wen_i,
    input  logic [NSRC*AW-1:0]   rd_i,
    input  logic [NSRC*XLEN-1:0] wdata_i,
    input  logic [NSRC*XLEN-1:0] pc_i,
    input  logic                 halt_i,
    output logic                 we_o,
    output logic [AW-1:0]        waddr_o,
    output logic [XLEN-1:0]      wdata_o,
    output logic                 commit_valid_o,
    output logic [XLEN-1:0]      commit_pc_o,
    output logic [63:0]          retire_cnt_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int PW = idxWidth(NSRC);
    // Queue entry layout, msb first: {wen, rd, wdata, pc}
    localparam int FW = 1 + AW + 2 * XLEN;

    logic [PW-1:0]   r_rrPtr;
    logic            r_commitValid;
    logic [XLEN-1:0] r_commitPc;
    logic [63:0]     r_retireCnt;

    logic            w_found;
    logic [PW-1:0]   w_grantIdx;
    logic [NSRC-1:0] w_grant;
    logic            w_accept;
    logic [FW-1:0]   w_pushData;
    logic [FW-1:0]   w_headData;
    logic            w_full;
    logic            w_empty;
    logic            w_drain;
    logic            w_headWen;
    logic [AW-1:0]   w_headRd;
    logic [XLEN-1:0] w_headWdata;
    logic [XLEN-1:0] w_headPc;

    // Round-robin scan: the first valid source found starting from r_rrPtr
    // wins. Only one source can be granted, so at most one enqueue per cycle.
    always_comb begin
        w_found    = 1'b0;
        w_grantIdx = '0;
        for (int off = 0; off < NSRC; off++) begin
            if (!w_found && valid_pre_i[rrIndex(int'(r_rrPtr), off, NSRC)]) begin
                w_found    = 1'b1;
                w_grantIdx = PW'(rrIndex(int'(r_rrPtr), off, NSRC));
            end
        end
    end

    // Ready is withheld from everyone while full, even when a drain would free
    // a slot in the same cycle; this keeps ready off the drain path.
    assign w_grant     = w_found ? (NSRC'(1) << w_grantIdx) : '0;
    assign ready_pre_o = w_grant & {NSRC{!w_full}};
    assign w_accept    = w_found && !w_full;

    assign w_pushData = {wen_i[w_grantIdx],
                         rd_i[int'(w_grantIdx) * AW +: AW],
                         wdata_i[int'(w_grantIdx) * XLEN +: XLEN],
                         pc_i[int'(w_grantIdx) * XLEN +: XLEN]};

    // The pointer moves past the source just served so that a continuously
    // requesting source cannot starve the others.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rrPtr <= '0;
        end else if (w_accept) begin
            if (w_grantIdx == PW'(NSRC - 1)) begin
                r_rrPtr <= '0;
            end else begin
                r_rrPtr <= w_grantIdx + 1'b1;
            end
        end
    end

    commit_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (w_accept),
        .pushData_i (w_pushData),
        .pop_i      (w_drain),
        .headData_o (w_headData),
        .full_o     (w_full),
        .empty_o    (w_empty)
    );

    assign w_headWen   = w_headData[FW-1];
    assign w_headRd    = w_headData[2*XLEN +: AW];
    assign w_headWdata = w_headData[XLEN +: XLEN];
    assign w_headPc    = w_headData[0 +: XLEN];

    // Drain straight from the head entry; writes to x0 still retire but never
    // reach the register file.
    assign w_drain = !w_empty && !halt_i;
    assign we_o    = w_drain && w_headWen && (w_headRd != '0);
    assign waddr_o = w_empty ? '0 : w_headRd;
    assign wdata_o = w_empty ? '0 : w_headWdata;
    assign full_o  = w_full;
    assign empty_o = w_empty;

    // Commit pulse lags the register write by one cycle, and the counter
    // counts pulses, so it lags one more cycle behind.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_commitValid <= 1'b0;
            r_commitPc    <= '0;
            r_retireCnt   <= '0;
        end else begin
            r_commitValid <= w_drain;
            r_commitPc    <= w_drain ? w_headPc : '0;
            if (r_commitValid) begin
                r_retireCnt <= r_retireCnt + 64'd1;
            end
        end
    end

    assign commit_valid_o = r_commitValid;
    assign commit_pc_o    = r_commitPc;
    assign retire_cnt_o   = r_retireCnt;

endmodule

// File: tb/tb_commit_queue.sv
// -----------------------------------------------------------------------------
// tb_commit_queue
// Scoreboard bench for commit_queue (NSRC=2, DEPTH=4). A reference model keeps
// the queue contents and round-robin position as plain SystemVerilog queues
// and integers; the stimulus side predicts handshakes and writes, and queues
// the PCs that must later appear as commit pulses. A separate monitor pops
// those PCs whenever the DUT pulses commit_valid_o.
// -----------------------------------------------------------------------------
module tb_commit_queue;

    localparam int NSRC  = 2;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int AW    = 5;

    typedef struct {
        logic            wen;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } item_t;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [NSRC-1:0]      valid_pre_i = '0;
    logic [NSRC-1:0]      ready_pre_o;
    logic [NSRC-1:0]      wen_i = '0;
    logic [NSRC*AW-1:0]   rd_i = '0;
    logic [NSRC*XLEN-1:0] wdata_i = '0;
    logic [NSRC*XLEN-1:0] pc_i = '0;
    logic                 halt_i = 1'b0;
    logic                 we_o;
    logic [AW-1:0]        waddr_o;
    logic [XLEN-1:0]      wdata_o;
    logic                 commit_valid_o;
    logic [XLEN-1:0]      commit_pc_o;
    logic [63:0]          retire_cnt_o;
    logic                 full_o;
    logic                 empty_o;

    item_t           modelQ[$];
    logic [XLEN-1:0] expPc[$];
    item_t           srcItem[NSRC];
    logic            srcHas[NSRC];
    int              rrPtr;
    int              pcSeq;
    longint unsigned monCount;
    int              checks;
    int              errors;

    always #5 clock = ~clock;

    commit_queue #(
        .NSRC  (NSRC),
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .AW    (AW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .valid_pre_i    (valid_pre_i),
        .ready_pre_o    (ready_pre_o),
        .wen_i          (wen_i),
        .rd_i           (rd_i),
        .wdata_i        (wdata_i),
        .pc_i           (pc_i),
        .halt_i         (halt_i),
        .we_o           (we_o),
        .waddr_o        (waddr_o),
        .wdata_o        (wdata_o),
        .commit_valid_o (commit_valid_o),
        .commit_pc_o    (commit_pc_o),
        .retire_cnt_o   (retire_cnt_o),
        .full_o         (full_o),
        .empty_o        (empty_o)
    );

    // One comparison: counts it, and reports it when the values disagree.
    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Load a specific result into a source's output register.
    task automatic loadSource(input int k, input logic wen, input logic [AW-1:0] rd,
                              input logic [XLEN-1:0] data, input logic [XLEN-1:0] pc);
        srcItem[k].wen  = wen;
        srcItem[k].rd   = rd;
        srcItem[k].data = data;
        srcItem[k].pc   = pc;
        srcHas[k]       = 1'b1;
    endtask

    // Load a random result; PCs are unique so commit order is unambiguous.
    task automatic loadRandom(input int k);
        pcSeq++;
        loadSource(k, ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 31)),
                   XLEN'($urandom), XLEN'(32'h0001_0000 + pcSeq * 4));
    endtask

    task automatic driveSources();
        for (int k = 0; k < NSRC; k++) begin
            valid_pre_i[k]            = srcHas[k];
            wen_i[k]                  = srcItem[k].wen;
            rd_i[k*AW +: AW]          = srcItem[k].rd;
            wdata_i[k*XLEN +: XLEN]   = srcItem[k].data;
            pc_i[k*XLEN +: XLEN]      = srcItem[k].pc;
        end
    endtask

    // Predict this cycle's handshake and write-port values from the model,
    // compare them, then advance the model across the coming clock edge.
    task automatic checkOutput(input logic h);
        int              g;
        logic [NSRC-1:0] expReady;
        bit              mFull;
        item_t           head;
        logic            expWe;
        logic [AW-1:0]   expAddr;
        logic [XLEN-1:0] expData;

        mFull = (modelQ.size() == DEPTH);
        g = -1;
        for (int off = 0; off < NSRC; off++) begin
            if (g < 0 && srcHas[(rrPtr + off) % NSRC]) begin
                g = (rrPtr + off) % NSRC;
            end
        end
        expReady = '0;
        if (g >= 0 && !mFull) begin
            expReady[g] = 1'b1;
        end
        cmp("ready_pre_o", 64'(ready_pre_o), 64'(expReady));
        cmp("full_o", 64'(full_o), 64'(mFull));
        cmp("empty_o", 64'(empty_o), 64'(modelQ.size() == 0));

        expWe   = 1'b0;
        expAddr = '0;
        expData = '0;
        if (modelQ.size() > 0) begin
            head    = modelQ[0];
            expAddr = head.rd;
            expData = head.data;
            if (!h) begin
                expWe = head.wen && (head.rd != 0);
                expPc.push_back(head.pc);
                void'(modelQ.pop_front());
            end
        end
        cmp("we_o", 64'(we_o), 64'(expWe));
        cmp("waddr_o", 64'(waddr_o), 64'(expAddr));
        cmp("wdata_o", 64'(wdata_o), 64'(expData));

        if (expReady != '0) begin
            modelQ.push_back(srcItem[g]);
            srcHas[g] = 1'b0;
            rrPtr     = (g + 1) % NSRC;
        end
    endtask

    // One cycle: sources without a pending result may pick up a new random
    // one (per 'offer'), inputs settle, then the cycle is checked.
    task automatic applyStimulus(input logic [NSRC-1:0] offer, input logic h);
        @(negedge clock);
        for (int k = 0; k < NSRC; k++) begin
            if (!srcHas[k] && offer[k]) begin
                loadRandom(k);
            end
        end
        driveSources();
        halt_i = h;
        #1;
        checkOutput(h);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic doReset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        for (int k = 0; k < NSRC; k++) begin
            srcHas[k] = 1'b0;
        end
        driveSources();
        #1;
        cmp("rst we_o", 64'(we_o), 64'd0);
        cmp("rst waddr_o", 64'(waddr_o), 64'd0);
        cmp("rst wdata_o", 64'(wdata_o), 64'd0);
        cmp("rst commit_valid_o", 64'(commit_valid_o), 64'd0);
        cmp("rst commit_pc_o", 64'(commit_pc_o), 64'd0);
        cmp("rst retire_cnt_o", retire_cnt_o, 64'd0);
        cmp("rst full_o", 64'(full_o), 64'd0);
        cmp("rst empty_o", 64'(empty_o), 64'd1);
        modelQ.delete();
        expPc.delete();
        rrPtr = 0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: every commit pulse must match the oldest predicted PC, every
    // predicted PC must show up right after its drain, and the counter must
    // equal the number of pulses seen before this cycle.
    initial begin
        monCount = 0;
        @(negedge reset);
        forever begin
            @(posedge clock);
            #2;
            if (reset) begin
                monCount = 0;
            end else begin
                cmp("retire_cnt_o", retire_cnt_o, 64'(monCount));
                if (commit_valid_o) begin
                    if (expPc.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL commit_pulse: got unexpected pulse pc 0x%0h expected none at %0t",
                                 commit_pc_o, $time);
                    end else begin
                        cmp("commit_pc_o", 64'(commit_pc_o), 64'(expPc.pop_front()));
                    end
                    monCount++;
                end else if (expPc.size() != 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL commit_pulse: got none expected pc 0x%0h at %0t", expPc[0], $time);
                    expPc.delete();
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rrPtr  = 0;
        pcSeq  = 0;
        for (int k = 0; k < NSRC; k++) begin
            srcHas[k]  = 1'b0;
            srcItem[k] = '{wen: 1'b0, rd: '0, data: '0, pc: '0};
        end
        #1;
        doReset();

        // Single source into an empty queue.
        loadSource(0, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h8000_0000);
        applyStimulus(2'b00, 1'b0);
        repeat (4) applyStimulus(2'b00, 1'b0);

        // Both sources valid for several cycles: accepts must alternate.
        repeat (4) applyStimulus(2'b11, 1'b0);
        repeat (4) applyStimulus(2'b00, 1'b0);

        // x0 write and a non-writing result still retire.
        loadSource(0, 1'b1, 5'd0, 32'h1234_5678, 32'h8000_0100);
        applyStimulus(2'b00, 1'b0);
        loadSource(1, 1'b0, 5'd5, 32'h8765_4321, 32'h8000_0104);
        applyStimulus(2'b00, 1'b0);
        repeat (4) applyStimulus(2'b00, 1'b0);

        // Fill under halt, fifth offer blocked, then release and keep pushing
        // so the pointers wrap.
        repeat (5) applyStimulus(2'b01, 1'b1);
        repeat (8) applyStimulus(2'b01, 1'b0);
        repeat (6) applyStimulus(2'b00, 1'b0);

        // Reset with three entries queued: nothing of them may retire.
        repeat (3) applyStimulus(2'b10, 1'b1);
        doReset();
        repeat (4) applyStimulus(2'b00, 1'b0);

        // Two queued, then enqueue and dequeue together.
        repeat (2) applyStimulus(2'b01, 1'b1);
        repeat (3) applyStimulus(2'b01, 1'b0);
        repeat (6) applyStimulus(2'b00, 1'b0);

        // Random traffic with random halts.
        repeat (400) applyStimulus(NSRC'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        repeat (10) applyStimulus(2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
